// File: rtl/pipeline_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_control_unit_if
// Brief   : Decoded-instruction handshake, flag inputs and datapath control
//           bundle for the pipeline control unit.
// Revision: 1.0
// ============================================================================
interface pipeline_control_unit_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       src1_adr;
    logic             src1_used;
    logic [2:0]       src2_adr;
    logic             src2_used;
    logic [2:0]       dst_adr;
    logic             dst_wr;
    logic             is_load;
    logic             is_store;
    logic [7:0]       alu_op;
    logic             alu_imm_sel;
    logic [15:0]      imm;
    logic             is_branch;
    logic [2:0]       cond;
    logic             N, Z, C, V;
    logic [2:0]       reg_read_adr1;
    logic [2:0]       reg_read_adr2;
    logic [7:0]       ALU_con;
    logic             ALU_source2;
    logic [15:0]      offset;
    logic [1:0]       forward1;
    logic [1:0]       forward2;
    logic             flush_e;
    logic             redirect;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [2:0]       reg_write_adr;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output instr_valid, src1_adr, src1_used, src2_adr, src2_used, dst_adr, dst_wr,
               is_load, is_store, alu_op, alu_imm_sel, imm, is_branch, cond, N, Z, C, V,
        input  instr_ready, reg_read_adr1, reg_read_adr2, ALU_con, ALU_source2, offset,
               forward1, forward2, flush_e, redirect, mem_write, mem_to_reg, reg_write,
               reg_write_adr, retired_count
    );

    modport slave (
        input  instr_valid, src1_adr, src1_used, src2_adr, src2_used, dst_adr, dst_wr,
               is_load, is_store, alu_op, alu_imm_sel, imm, is_branch, cond, N, Z, C, V,
        output instr_ready, reg_read_adr1, reg_read_adr2, ALU_con, ALU_source2, offset,
               forward1, forward2, flush_e, redirect, mem_write, mem_to_reg, reg_write,
               reg_write_adr, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_control_unit
// Brief   : D/E/M/W control sequencer with forwarding, load-use stall,
//           branch flush and saturating retired-instruction counter.
// Revision: 1.0
// ============================================================================
module pipeline_control_unit #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  wire                      clock,
    input  wire                      reset_n,
    pipeline_control_unit_if.slave   bus
);
    logic        r_e_valid, r_e_src1_used, r_e_src2_used, r_e_dst_wr;
    logic        r_e_is_load, r_e_is_store, r_e_alu_imm_sel, r_e_is_branch;
    logic [2:0]  r_e_src1, r_e_src2, r_e_dst, r_e_cond;
    logic [7:0]  r_e_alu_op;
    logic [15:0] r_e_imm;
    logic        r_m_valid, r_m_dst_wr, r_m_is_load, r_m_is_store;
    logic [2:0]  r_m_dst;
    logic        r_w_valid, r_w_dst_wr, r_w_is_load;
    logic [2:0]  r_w_dst;
    logic [CNT_W-1:0] r_retired;

    logic        w_cond_true, w_taken, w_stall, w_ready, w_accept, w_d_dst_wr;
    logic        w_hit_e1, w_hit_e2;
    logic [1:0]  w_fwd1, w_fwd2;

    always_comb begin
        w_cond_true = 1'b0;
        case (r_e_cond)
            3'd0:    w_cond_true = 1'b1;
            3'd1:    w_cond_true = bus.Z;
            3'd2:    w_cond_true = ~bus.Z;
            3'd3:    w_cond_true = bus.N;
            3'd4:    w_cond_true = ~bus.N;
            3'd5:    w_cond_true = bus.C;
            3'd6:    w_cond_true = ~bus.C;
            default: w_cond_true = bus.V;
        endcase
    end

    assign w_taken    = r_e_valid & r_e_is_branch & w_cond_true;
    assign w_d_dst_wr = bus.dst_wr & ~bus.is_branch & ~bus.is_store;
    assign w_hit_e1   = bus.src1_used & (bus.src1_adr == r_e_dst) & r_e_valid & r_e_dst_wr;
    assign w_hit_e2   = bus.src2_used & (bus.src2_adr == r_e_dst) & r_e_valid & r_e_dst_wr;

    generate
        if (FWD_EN) begin : g_fwd
            // A load in M has no result yet, so it can only be picked up once in W.
            function automatic logic [1:0] f_fwd_sel(input logic used, input logic [2:0] src);
                if (!(r_e_valid && used))                                  return 2'd0;
                if (r_m_valid && r_m_dst_wr && !r_m_is_load && r_m_dst == src) return 2'd1;
                if (r_w_valid && r_w_dst_wr && r_w_dst == src)             return 2'd2;
                return 2'd0;
            endfunction

            assign w_stall = bus.instr_valid & r_e_is_load & (w_hit_e1 | w_hit_e2);
            assign w_fwd1  = f_fwd_sel(r_e_src1_used, r_e_src1);
            assign w_fwd2  = f_fwd_sel(r_e_src2_used, r_e_src2);
        end else begin : g_nofwd
            logic w_hit_m1, w_hit_m2;
            assign w_hit_m1 = bus.src1_used & (bus.src1_adr == r_m_dst) & r_m_valid & r_m_dst_wr;
            assign w_hit_m2 = bus.src2_used & (bus.src2_adr == r_m_dst) & r_m_valid & r_m_dst_wr;
            assign w_stall  = bus.instr_valid & (w_hit_e1 | w_hit_e2 | w_hit_m1 | w_hit_m2);
            assign w_fwd1   = 2'd0;
            assign w_fwd2   = 2'd0;
        end
    endgenerate

    // A taken branch overrides any stall: the D instruction is consumed and dropped.
    assign w_ready  = w_taken | ~w_stall;
    assign w_accept = bus.instr_valid & w_ready & ~w_taken;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_e_valid <= 1'b0; r_e_src1_used <= 1'b0; r_e_src2_used <= 1'b0; r_e_dst_wr <= 1'b0;
            r_e_is_load <= 1'b0; r_e_is_store <= 1'b0; r_e_alu_imm_sel <= 1'b0; r_e_is_branch <= 1'b0;
            r_e_src1 <= 3'd0; r_e_src2 <= 3'd0; r_e_dst <= 3'd0; r_e_cond <= 3'd0;
            r_e_alu_op <= 8'd0; r_e_imm <= 16'd0;
            r_m_valid <= 1'b0; r_m_dst_wr <= 1'b0; r_m_is_load <= 1'b0; r_m_is_store <= 1'b0;
            r_m_dst <= 3'd0;
            r_w_valid <= 1'b0; r_w_dst_wr <= 1'b0; r_w_is_load <= 1'b0; r_w_dst <= 3'd0;
            r_retired <= '0;
        end else begin
            r_e_valid       <= w_accept;
            r_e_src1_used   <= bus.src1_used;
            r_e_src2_used   <= bus.src2_used;
            r_e_dst_wr      <= w_d_dst_wr;
            r_e_is_load     <= bus.is_load;
            r_e_is_store    <= bus.is_store;
            r_e_alu_imm_sel <= bus.alu_imm_sel;
            r_e_is_branch   <= bus.is_branch;
            r_e_src1        <= bus.src1_adr;
            r_e_src2        <= bus.src2_adr;
            r_e_dst         <= bus.dst_adr;
            r_e_cond        <= bus.cond;
            r_e_alu_op      <= bus.alu_op;
            r_e_imm         <= bus.imm;

            r_m_valid    <= r_e_valid;
            r_m_dst_wr   <= r_e_dst_wr;
            r_m_is_load  <= r_e_is_load;
            r_m_is_store <= r_e_is_store;
            r_m_dst      <= r_e_dst;

            r_w_valid   <= r_m_valid;
            r_w_dst_wr  <= r_m_dst_wr;
            r_w_is_load <= r_m_is_load;
            r_w_dst     <= r_m_dst;

            if (r_w_valid && (r_retired != {CNT_W{1'b1}}))
                r_retired <= r_retired + 1'b1;
        end
    end

    assign bus.instr_ready   = w_ready;
    assign bus.reg_read_adr1 = bus.src1_adr;
    assign bus.reg_read_adr2 = bus.src2_adr;
    assign bus.ALU_con       = r_e_valid ? r_e_alu_op : 8'd0;
    assign bus.ALU_source2   = r_e_valid & r_e_alu_imm_sel;
    assign bus.offset        = r_e_valid ? r_e_imm : 16'd0;
    assign bus.forward1      = w_fwd1;
    assign bus.forward2      = w_fwd2;
    assign bus.flush_e       = w_taken;
    assign bus.redirect      = w_taken;
    assign bus.mem_write     = r_m_valid & r_m_is_store;
    assign bus.mem_to_reg    = r_w_valid & r_w_is_load;
    assign bus.reg_write     = r_w_valid & r_w_dst_wr;
    assign bus.reg_write_adr = r_w_valid ? r_w_dst : 3'd0;
    assign bus.retired_count = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_control_unit
// Brief   : Scoreboard bench: driver queues expected E-stage and W-stage
//           responses, a negedge monitor pops and compares them.
// Revision: 1.0
// ============================================================================
module tb_pipeline_control_unit;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    pipeline_control_unit_if #(.CNT_W(16)) if1 ();
    pipeline_control_unit_if #(.CNT_W(2))  if2 ();

    pipeline_control_unit #(.FWD_EN(1'b1), .CNT_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .bus(if1.slave));
    pipeline_control_unit #(.FWD_EN(1'b1), .CNT_W(2)) u_dut_sat (
        .clock(clock), .reset_n(reset_n), .bus(if2.slave));

    assign if2.instr_valid = if1.instr_valid;  assign if2.src1_adr  = if1.src1_adr;
    assign if2.src1_used   = if1.src1_used;    assign if2.src2_adr  = if1.src2_adr;
    assign if2.src2_used   = if1.src2_used;    assign if2.dst_adr   = if1.dst_adr;
    assign if2.dst_wr      = if1.dst_wr;       assign if2.is_load   = if1.is_load;
    assign if2.is_store    = if1.is_store;     assign if2.alu_op    = if1.alu_op;
    assign if2.alu_imm_sel = if1.alu_imm_sel;  assign if2.imm       = if1.imm;
    assign if2.is_branch   = if1.is_branch;    assign if2.cond      = if1.cond;
    assign if2.N = if1.N; assign if2.Z = if1.Z; assign if2.C = if1.C; assign if2.V = if1.V;

    typedef struct packed { logic [7:0] op; logic [1:0] f1; logic [1:0] f2; logic tk; } e_exp_t;
    typedef struct packed { logic [2:0] dst; logic ld; } wb_exp_t;
    e_exp_t  e_q[$];
    wb_exp_t wb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: an E-stage instruction is visible whenever ALU_con is nonzero.
    always @(negedge clock) begin
        if (reset_n) begin
            if (if1.ALU_con != 8'h00) begin
                if (e_q.size() == 0) chk("e_unexpected", {24'd0, if1.ALU_con}, 32'd0);
                else begin
                    e_exp_t ex;
                    ex = e_q.pop_front();
                    chk("e_op",     {24'd0, if1.ALU_con}, {24'd0, ex.op});
                    chk("forward1", {30'd0, if1.forward1}, {30'd0, ex.f1});
                    chk("forward2", {30'd0, if1.forward2}, {30'd0, ex.f2});
                    chk("flush_e",  {31'd0, if1.flush_e},  {31'd0, ex.tk});
                    chk("redirect", {31'd0, if1.redirect}, {31'd0, ex.tk});
                end
            end else if (if1.flush_e || if1.redirect) begin
                chk("flush_on_bubble", {30'd0, if1.flush_e, if1.redirect}, 32'd0);
            end
            if (if1.reg_write) begin
                if (wb_q.size() == 0) chk("wb_unexpected", {29'd0, if1.reg_write_adr}, 32'hFFFF);
                else begin
                    wb_exp_t wx;
                    wx = wb_q.pop_front();
                    chk("reg_write_adr", {29'd0, if1.reg_write_adr}, {29'd0, wx.dst});
                    chk("mem_to_reg",    {31'd0, if1.mem_to_reg},    {31'd0, wx.ld});
                end
            end
        end
    end

    task automatic idle(input int n);
        if1.instr_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] d,
                        input logic wr, input logic ld, input logic st, input logic br,
                        input logic [2:0] cnd, input logic [1:0] f1, input logic [1:0] f2,
                        input logic tk, input logic fl, input int exp_stalls);
        int  stalls = 0;
        bit  ok = 1'b0;
        e_exp_t  ex;
        wb_exp_t wx;
        if1.alu_op = op; if1.src1_adr = s1; if1.src1_used = u1; if1.src2_adr = s2;
        if1.src2_used = u2; if1.dst_adr = d; if1.dst_wr = wr; if1.is_load = ld;
        if1.is_store = st; if1.is_branch = br; if1.cond = cnd; if1.imm = {8'h00, op};
        if1.alu_imm_sel = 1'b0; if1.instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (if1.instr_ready) begin ok = 1'b1; break; end
            stalls++;
        end
        if (!ok) begin
            chk($sformatf("ready_timeout_%0h", op), 32'd0, 32'd1);
            if1.instr_valid = 1'b0;
            return;
        end
        chk($sformatf("stall_cycles_%0h", op), stalls, exp_stalls);
        @(posedge clock);
        ex = '{op: op, f1: f1, f2: f2, tk: tk};
        wx = '{dst: d, ld: ld};
        if (!fl) e_q.push_back(ex);
        if (!fl && wr && !br && !st) wb_q.push_back(wx);
        #1;
        if1.instr_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ALU_con"},   {24'd0, if1.ALU_con}, 32'd0);
        chk({tag, "_fwd"},       {28'd0, if1.forward1, if1.forward2}, 32'd0);
        chk({tag, "_flush"},     {30'd0, if1.flush_e, if1.redirect}, 32'd0);
        chk({tag, "_mem"},       {30'd0, if1.mem_write, if1.mem_to_reg}, 32'd0);
        chk({tag, "_reg_write"}, {28'd0, if1.reg_write, if1.reg_write_adr}, 32'd0);
        chk({tag, "_retired"},   {16'd0, if1.retired_count}, 32'd0);
    endtask

    initial begin
        if1.instr_valid = 1'b0; if1.src1_adr = 3'd0; if1.src1_used = 1'b0;
        if1.src2_adr = 3'd0; if1.src2_used = 1'b0; if1.dst_adr = 3'd0; if1.dst_wr = 1'b0;
        if1.is_load = 1'b0; if1.is_store = 1'b0; if1.alu_op = 8'd0; if1.alu_imm_sel = 1'b0;
        if1.imm = 16'd0; if1.is_branch = 1'b0; if1.cond = 3'd0;
        if1.N = 1'b0; if1.Z = 1'b0; if1.C = 1'b0; if1.V = 1'b0;

        repeat (3) @(posedge clock);
        #2;
        chk_all_zero("reset");
        chk("reset_ready", {31'd0, if1.instr_ready}, 32'd1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Retirement counting: 5 instructions, 2 bubbles.
        send(8'h01, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        idle(1);
        send(8'h02, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h03, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        idle(1);
        send(8'h04, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h05, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        idle(6);
        chk("retired_5",   {16'd0, if1.retired_count}, 32'd5);
        chk("retired_sat", {30'd0, if2.retired_count}, 32'd3);

        // Reset with three instructions in flight.
        send(8'h10, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h11, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h12, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        e_q.delete();
        wb_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(5);
        chk("retired_after_reset", {16'd0, if1.retired_count}, 32'd0);

        // ALU chain: r1<=r2+r3 ; r4<=r1+r1 forwards both operands from M.
        send(8'h20, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h21, 3'd1, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd1, 1'b0, 1'b0, 0);
        idle(4);

        // Gap of one picks up W; gap of three sees the register file.
        send(8'h22, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h23, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h24, 3'd1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 1'b0, 1'b0, 0);
        idle(4);
        send(8'h25, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        idle(3);
        send(8'h26, 3'd1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        idle(4);

        // Load-use: one stall cycle, then the loaded value comes from W.
        send(8'h30, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h31, 3'd2, 1'b1, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1);
        idle(4);

        // Branch NE with Z=0: taken, shadow instruction squashed.
        if1.Z = 1'b0;
        send(8'h40, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0, 2'd0, 1'b1, 1'b0, 0);
        send(8'h41, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 0);
        send(8'h42, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        idle(4);

        // Branch NE with Z=1: not taken; following store never writes a register.
        if1.Z = 1'b1;
        send(8'h43, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h44, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 0);
        send(8'h45, 3'd5, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 2'd0, 1'b0, 1'b0, 0);
        idle(6);

        chk("e_queue_drained",  e_q.size(),  32'd0);
        chk("wb_queue_drained", wb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
